regfile_wb_arbiter: RTL and testbench

Write-back arbiter and sequencer for the register file's single write port. Up to NUM_REQ completing units (ALU, load unit, multiplier, CSR) compete for the one regwr/rd/data port; this block grants one per cycle round-robin, registers the winning write, and drives the port. It also sequences the reset-time stack-pointer initialization (x2) and exposes the in-flight write for bypassing.

---
 rtl/p6_pkg.sv | 22 ++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/p6_pkg.sv
// rtl/p6_pkg.sv - shared types and constants for the register-file write-back arbiter
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef NUMBER_OF_REGISTERS_B
`define NUMBER_OF_REGISTERS_B 5
`endif

package p6_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } wb_state_e;

  localparam int DATA_W = `DATA_SIZE;
  localparam int RD_W   = `NUMBER_OF_REGISTERS_B;

  localparam logic [DATA_W-1:0] SP_INIT_DEFAULT = 32'h0000_FFFC;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rtl/regfile_wb_arbiter_rr_arbiter.sv - round-robin pick: first set request at or after the pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  int          j;
  logic [IW-1:0] jv;

  // Scan from the farthest offset down so the nearest requester to ptr_i wins last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    jv      = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      j = int'(ptr_i) + off;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jv = IW'(j);
      if (req_i[jv]) begin
        grant_o     = '0;
        grant_o[jv] = 1'b1;
        idx_o       = jv;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - grants the single register-file write port round-robin and registers the winner
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef NUMBER_OF_REGISTERS_B
`define NUMBER_OF_REGISTERS_B 5
`endif

module regfile_wb_arbiter
  import p6_pkg::*;
#(
  parameter int                      NUM_REQ = 4,
  parameter logic [`DATA_SIZE-1:0]   SP_INIT = SP_INIT_DEFAULT
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [NUM_REQ-1:0][`NUMBER_OF_REGISTERS_B-1:0] req_rd,
  input  logic [NUM_REQ-1:0][`DATA_SIZE-1:0]            req_data,
  output logic [NUM_REQ-1:0]                            req_ready,
  input  logic                                          wb_hold,
  output logic                                          rf_regwr,
  output logic [`NUMBER_OF_REGISTERS_B-1:0]             rf_rd,
  output logic [`DATA_SIZE-1:0]                         rf_data,
  output logic                                          fwd_valid,
  output logic [`NUMBER_OF_REGISTERS_B-1:0]             fwd_rd,
  output logic [`DATA_SIZE-1:0]                         fwd_data
);

  localparam int IW = $clog2(NUM_REQ);

  wb_state_e                        state_q, state_d;
  logic [IW-1:0]                    rr_ptr_q, rr_ptr_d;
  logic                             wr_valid_q, wr_valid_d;
  logic [`NUMBER_OF_REGISTERS_B-1:0] rd_q, rd_d;
  logic [`DATA_SIZE-1:0]            data_q, data_d;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic               grant_en;
  logic               xfer;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  // HOLD only marks that the previous cycle was stalled; grants resume the cycle wb_hold drops.
  assign grant_en  = !reset && (state_q != INIT) && !wb_hold;
  assign req_ready = grant_en ? grant : '0;
  assign xfer      = grant_en && win_any;

  always_comb begin
    state_d    = wb_hold ? HOLD : RUN;
    rr_ptr_d   = rr_ptr_q;
    wr_valid_d = 1'b0;
    rd_d       = rd_q;
    data_d     = data_q;
    if (xfer) begin
      wr_valid_d = 1'b1;
      rd_d       = req_rd[win_idx];
      data_d     = req_data[win_idx];
      rr_ptr_d   = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      rr_ptr_q   <= '0;
      wr_valid_q <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_valid_q <= wr_valid_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
    end
  end

  // During reset the port carries SP_INIT so the register file can seed x2.
  assign rf_regwr  = wr_valid_q && !reset;
  assign rf_rd     = rd_q;
  assign rf_data   = reset ? SP_INIT : data_q;

  assign fwd_valid = rf_regwr && (rd_q != '0);
  assign fwd_rd    = rd_q;
  assign fwd_data  = data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed bench for the write-back arbiter with a small register-file model
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef NUMBER_OF_REGISTERS_B
`define NUMBER_OF_REGISTERS_B 5
`endif

module tb_regfile_wb_arbiter;

  localparam int N = 4;

  logic                                   clk;
  logic                                   reset;
  logic [N-1:0]                           req_valid;
  logic [N-1:0][`NUMBER_OF_REGISTERS_B-1:0] req_rd;
  logic [N-1:0][`DATA_SIZE-1:0]           req_data;
  logic [N-1:0]                           req_ready;
  logic                                   wb_hold;
  logic                                   rf_regwr;
  logic [`NUMBER_OF_REGISTERS_B-1:0]      rf_rd;
  logic [`DATA_SIZE-1:0]                  rf_data;
  logic                                   fwd_valid;
  logic [`NUMBER_OF_REGISTERS_B-1:0]      fwd_rd;
  logic [`DATA_SIZE-1:0]                  fwd_data;

  logic [`DATA_SIZE-1:0] rf [0:31];

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.NUM_REQ(N), .SP_INIT(32'h0000_FFFC)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wb_hold   (wb_hold),
    .rf_regwr  (rf_regwr),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: x2 seeded from the port during reset, x0 hardwired to zero.
  always @(posedge clk) begin
    if (reset) rf[2] <= rf_data;
    else if (rf_regwr && rf_rd != '0) rf[rf_rd] <= rf_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset     = 1'b1;
    wb_hold   = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) begin
      req_rd[i]   = 5'(10 + i);
      req_data[i] = 32'h100 + 32'(i);
    end

    tick();
    check_eq("reset_rf_data", rf_data, 32'h0000_FFFC);
    check_eq("reset_regwr", {31'b0, rf_regwr}, 32'd0);
    check_eq("reset_ready", {28'b0, req_ready}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("init_ready", {28'b0, req_ready}, 32'd0);
    check_eq("init_regwr", {31'b0, rf_regwr}, 32'd0);
    check_eq("x2_sp_init", rf[2], 32'h0000_FFFC);
    tick();

    for (int k = 0; k < 5; k++) begin
      check_eq("rr_ready", {28'b0, req_ready}, 32'(1 << (k % 4)));
      if (k > 0) begin
        check_eq("rr_rf_rd", {27'b0, rf_rd}, 32'(10 + (k - 1) % 4));
        check_eq("rr_rf_data", rf_data, 32'h100 + 32'((k - 1) % 4));
        check_eq("rr_regwr", {31'b0, rf_regwr}, 32'd1);
      end
      tick();
    end
    req_valid = '0;
    #1;
    check_eq("rr_last_rd", {27'b0, rf_rd}, 32'd10);
    check_eq("rr_last_data", rf_data, 32'h100);
    check_eq("idle_ready", {28'b0, req_ready}, 32'd0);
    tick();

    req_rd[2] = 5'd5; req_data[2] = 32'hAAAA_0001;
    req_rd[3] = 5'd5; req_data[3] = 32'hBBBB_0002;
    req_valid = 4'b0100;
    #1;
    check_eq("x5_grant2", {28'b0, req_ready}, 32'b0100);
    tick();
    req_valid = 4'b1000;
    #1;
    check_eq("x5_grant3", {28'b0, req_ready}, 32'b1000);
    check_eq("x5_fwd_valid", {31'b0, fwd_valid}, 32'd1);
    check_eq("x5_fwd_rd", {27'b0, fwd_rd}, 32'd5);
    check_eq("x5_fwd_a", fwd_data, 32'hAAAA_0001);
    tick();
    req_valid = '0;
    #1;
    check_eq("x5_fwd_b", fwd_data, 32'hBBBB_0002);
    check_eq("x5_first", rf[5], 32'hAAAA_0001);
    tick();
    check_eq("x5_final", rf[5], 32'hBBBB_0002);
    check_eq("x5_idle_regwr", {31'b0, rf_regwr}, 32'd0);

    req_rd[1] = 5'd0; req_data[1] = 32'h1234;
    req_valid = 4'b0010;
    #1;
    check_eq("x0_grant", {28'b0, req_ready}, 32'b0010);
    tick();
    req_valid = '0;
    #1;
    check_eq("x0_regwr", {31'b0, rf_regwr}, 32'd1);
    check_eq("x0_rf_rd", {27'b0, rf_rd}, 32'd0);
    check_eq("x0_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    tick();
    check_eq("x0_reads_zero", rf[0], 32'd0);

    req_rd[0] = 5'd9; req_data[0] = 32'h99;
    req_valid = 4'b0001;
    #1;
    check_eq("hold_pre_grant", {28'b0, req_ready}, 32'b0001);
    tick();
    wb_hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      #1;
      check_eq("hold_ready", {28'b0, req_ready}, 32'd0);
      if (h == 0) begin
        check_eq("hold_issue_regwr", {31'b0, rf_regwr}, 32'd1);
        check_eq("hold_issue_rd", {27'b0, rf_rd}, 32'd9);
      end else begin
        check_eq("hold_no_regwr", {31'b0, rf_regwr}, 32'd0);
      end
      tick();
    end
    wb_hold = 1'b0;
    #1;
    check_eq("hold_resume", {28'b0, req_ready}, 32'b0001);
    tick();

    req_valid = 4'b0100;
    req_rd[2] = 5'd7; req_data[2] = 32'h55;
    #1;
    check_eq("rst_xfer_grant", {28'b0, req_ready}, 32'b0100);
    tick();
    reset = 1'b1;
    req_valid = '0;
    #1;
    check_eq("rst_regwr", {31'b0, rf_regwr}, 32'd0);
    check_eq("rst_rf_data", rf_data, 32'h0000_FFFC);
    check_eq("rst_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    tick();
    reset = 1'b0;
    req_valid = 4'hF;
    #1;
    check_eq("rst_init_ready", {28'b0, req_ready}, 32'd0);
    check_eq("x7_unwritten", rf[7], 32'd0);
    tick();
    check_eq("rst_ptr_zero", {28'b0, req_ready}, 32'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
